// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, 2-of-3 majority per bit, optional parity,
// one-cycle result pulses (Data_valid / Par_err / Stp_err) after each frame.
module uart_rx #(
  parameter int Width = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             RX_IN,
  input  logic [5:0]       Prescale,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [Width-1:0] P_data,
  output logic             Data_valid,
  output logic             Par_err,
  output logic             Stp_err
);

  localparam int BcW = (Width > 1) ? $clog2(Width) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_e;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  function automatic logic parity_bit(input logic [Width-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic [1:0]       sync_q;
  logic             line_s;
  logic [1:0]       line_ok_q, line_ok_d;
  logic             armed_q, armed_d;
  state_e           state_q, state_d;
  logic [5:0]       edge_q, edge_d;
  logic [BcW-1:0]   bit_q, bit_d;
  logic [5:0]       p_q, p_d;
  logic             par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic [2:0]       smp_q, smp_d;
  logic [Width-1:0] shift_q, shift_d;
  logic             perr_q, perr_d, serr_q, serr_d;
  logic [Width-1:0] p_data_q, p_data_d;
  logic             dv_q, dv_d, pe_q, pe_d, se_q, se_d;
  logic [5:0]       mid_s, p_sel_s;
  logic             bit_end_s, in_win_s, maj_s;

  assign line_s    = sync_q[1];
  assign mid_s     = {1'b0, p_q[5:1]};
  assign bit_end_s = (edge_q == (p_q - 6'd1));
  assign in_win_s  = (edge_q == (mid_s - 6'd1)) || (edge_q == mid_s) || (edge_q == (mid_s + 6'd1));
  assign maj_s     = maj3(smp_q);

  // Next-state, counters, sampling and result pulses
  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    bit_d     = bit_q;
    p_d       = p_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    smp_d     = smp_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    serr_d    = serr_q;
    p_data_d  = p_data_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;
    // Arming needs a line high that came from RX_IN, not from the reset value
    line_ok_d = {line_ok_q[0], 1'b1};
    armed_d   = armed_q | (line_ok_q[1] & line_s);

    case (Prescale)
      6'd8, 6'd16, 6'd32: p_sel_s = Prescale;
      default:            p_sel_s = 6'd8;
    endcase

    if ((state_q != IDLE) && (state_q != DONE)) begin
      edge_d = bit_end_s ? 6'd0 : (edge_q + 6'd1);
      if (in_win_s) begin
        smp_d = {smp_q[1:0], line_s};
      end else begin
        smp_d = smp_q;
      end
    end else begin
      edge_d = 6'd0;
    end

    case (state_q)
      IDLE: begin
        if (armed_q && !line_s) begin
          state_d   = START;
          edge_d    = 6'd0;
          bit_d     = '0;
          p_d       = p_sel_s;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          perr_d    = 1'b0;
          serr_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d = maj_s ? IDLE : DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_d[bit_q] = maj_s;
          if (bit_q == BcW'(Width - 1)) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + {{(BcW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          perr_d  = (maj_s != parity_bit(shift_q, par_typ_q));
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          serr_d  = !maj_s;
          state_d = DONE;
        end else begin
          state_d = STOP;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!perr_q && !serr_q) begin
          p_data_d = shift_q;
          dv_d     = 1'b1;
        end else begin
          pe_d = perr_q;
          se_d = serr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (rst) begin
      sync_q    <= 2'b11;
      line_ok_q <= 2'b00;
      armed_q   <= 1'b0;
      state_q   <= IDLE;
      edge_q    <= 6'd0;
      bit_q     <= '0;
      p_q       <= 6'd8;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      smp_q     <= 3'b000;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
      p_data_q  <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], RX_IN};
      line_ok_q <= line_ok_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      p_q       <= p_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      smp_q     <= smp_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
      p_data_q  <= p_data_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign P_data     = p_data_q;
  assign Data_valid = dv_q;
  assign Par_err    = pe_q;
  assign Stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed corner frames plus randomized frames,
// compared against a frame-level model of expected pulses, data and latency.
module tb_uart_rx;
  logic       CLK = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_data;
  logic       Data_valid, Par_err, Stp_err;

  uart_rx #(.Width(8)) dut (
    .CLK(CLK), .rst(rst), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .P_data(P_data), .Data_valid(Data_valid), .Par_err(Par_err),
    .Stp_err(Stp_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected result pulse: kind = {Stp_err, Par_err, Data_valid}
  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         e0;
    int         lat;
    bit         b2b;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] good_word = 8'h00;

  // Each result pulse must match the oldest expected frame outcome
  always @(negedge CLK) begin
    if (!rst && (Data_valid || Par_err || Stp_err)) begin
      logic [2:0] kind;
      int         obs_lat;
      exp_t       e;
      kind = {Stp_err, Par_err, Data_valid};
      if (exp_q.size() == 0) begin
        chk_eq("unexpected_pulse", {29'd0, kind}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        // cycle 1 is the one following the edge that first samples RX_IN low
        obs_lat = cyc - e.e0 + 1;
        chk_eq("pulse_kind", {29'd0, kind}, {29'd0, e.kind});
        chk_eq("p_data", {24'd0, P_data}, {24'd0, e.data});
        if (!e.b2b) chk_eq("latency", obs_lat, e.lat);
        else chk_eq("latency_b2b", {31'd0, (obs_lat >= e.lat) && (obs_lat <= e.lat + 2)}, 32'd1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic [5:0] pres, input bit pe,
                            input bit typ, input bit flip_par, input bit bad_stop,
                            input int abort_bit, input bit b2b);
    int   p, nbits, e0;
    logic par;
    exp_t e;
    p = (pres == 6'd8 || pres == 6'd16 || pres == 6'd32) ? int'(pres) : 8;
    nbits = 10 + (pe ? 1 : 0);
    par = (^data) ^ typ ^ flip_par;
    Prescale = pres; PAR_EN = pe; PAR_TYP = typ;
    e0 = cyc + 1;
    RX_IN = 1'b0;
    idle(p);
    // configuration pins are don't-care once the frame has started
    Prescale = 6'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      RX_IN = data[i];
      if (i == abort_bit) begin
        idle(3);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        good_word = 8'h00;
        chk_eq("abort_pdata", {24'd0, P_data}, 32'd0);
        idle(20);
        RX_IN = 1'b1;
        return;
      end
      idle(p);
    end
    if (pe) begin
      RX_IN = par;
      idle(p);
    end
    RX_IN = !bad_stop;
    idle(p);
    RX_IN = 1'b1;
    e.e0  = e0;
    e.lat = 2 + 1 + p * nbits + 1;
    e.b2b = b2b;
    if (!(pe && flip_par) && !bad_stop) begin
      e.kind = 3'b001;
      good_word = data;
    end else begin
      e.kind = {bad_stop, pe && flip_par, 1'b0};
    end
    e.data = good_word;
    exp_q.push_back(e);
  endtask

  initial begin
    RX_IN = 1'b1; rst = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    idle(3);
    chk_eq("rst_pdata", {24'd0, P_data}, 32'd0);
    chk_eq("rst_dv", {31'd0, Data_valid}, 32'd0);
    chk_eq("rst_perr", {31'd0, Par_err}, 32'd0);
    chk_eq("rst_serr", {31'd0, Stp_err}, 32'd0);
    rst = 1'b0;
    idle(5);

    send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);   idle(10);
    send_frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0);  idle(10);
    send_frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b0);  idle(10);
    send_frame(8'h5A, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);   idle(10);

    // short glitch must be rejected silently
    Prescale = 6'd16;
    RX_IN = 1'b0;
    idle(3);
    RX_IN = 1'b1;
    idle(40);
    send_frame(8'h81, 6'd16, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);  idle(10);

    send_frame(8'h12, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    send_frame(8'h34, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b1);  idle(10);

    // reset lands in data bit 4 (a 0 bit) and RX_IN stays low after release
    send_frame(8'hE5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0);    idle(10);
    send_frame(8'hF0, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);   idle(10);

    for (int k = 0; k < 12; k++) begin
      logic [5:0] pres;
      case ($urandom_range(0, 3))
        0: pres = 6'd8;
        1: pres = 6'd16;
        2: pres = 6'd32;
        default: pres = 6'd12;
      endcase
      send_frame(8'($urandom), pres, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, -1, 1'b0);
      idle($urandom_range(4, 20));
    end

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge CLK);
    idle(5);
    chk_eq("drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: Width, default 8, data bits per frame.
REQ-002 SHALL have port: CLK  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: RX_IN  input  1  serial line, idles high, asynchronous to CLK.
REQ-005 SHALL have port: Prescale  input  6  CLK cycles per bit; legal values 8, 16, 32.
REQ-006 SHALL have port: PAR_EN  input  1  1 = parity bit present after data.
REQ-007 SHALL have port: PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port: P_data  output  Width  last correctly received data word.
REQ-009 SHALL have port: Data_valid  output  1  one-cycle pulse, P_data updated.
REQ-010 SHALL have port: Par_err  output  1  one-cycle pulse, parity mismatch.
REQ-011 SHALL have port: Stp_err  output  1  one-cycle pulse, stop bit sampled 0.

Function
REQ-012 SHALL pass RX_IN through a 2-flop synchronizer (both flops reset to 1); "line" below means the synchronizer output.
REQ-013 SHALL use frame format: start (0), Width data bits LSB first, optional parity, one stop (1).
REQ-014 SHALL implement FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
REQ-015 SHALL, in IDLE, go to START in the cycle after line is sampled 0, clearing the edge counter and bit counter.
REQ-016 SHALL latch Prescale, PAR_EN and PAR_TYP on the IDLE->START transition; mid-frame input changes SHALL NOT affect the frame.
REQ-017 SHALL treat a latched Prescale value other than 8, 16 or 32 as 8.
REQ-018 SHALL use an edge counter that counts 0..P-1 per bit (P = latched prescale) and wraps to 0 at P-1.
REQ-019 SHALL sample each bit at edge counts P/2-1, P/2 and P/2+1, and take the bit value as the 2-of-3 majority.
REQ-020 SHALL, in START, return to IDLE at count P-1 with no output pulse if the start majority is 1 (glitch reject).
REQ-021 SHALL, in DATA, shift the majority bit into position bit_count at each bit end; after bit Width-1, go to PARITY if PAR_EN=1, else to STOP.
REQ-022 SHALL, in PARITY, compare the majority bit to the expected bit (XOR of the data bits, inverted when PAR_TYP=1) and record any mismatch.
REQ-023 SHALL, in STOP, record a stop error when the majority bit is 0; at count P-1, go to DONE.
REQ-024 SHALL, in DONE (one cycle): if no error is recorded, load P_data from the shift register and pulse Data_valid; otherwise pulse Par_err and/or Stp_err (both when both errors apply), leaving P_data unchanged. Next state SHALL be IDLE.
REQ-025 SHALL accept back-to-back frames: a start bit beginning right after the stop bit is detected from IDLE with no lost frame.
REQ-026 SHALL keep Data_valid, Par_err and Stp_err mutually exclusive with respect to Data_valid, each high for exactly one cycle per frame.
REQ-027 SHALL have frame latency: Data_valid asserted (2 + 1 + P x (Width + 2 + PAR_EN) + 1) cycles after the first CLK edge that samples RX_IN low.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, set the FSM to IDLE, all counters to 0, synchronizer flops to 1, P_data to 0, and Data_valid, Par_err and Stp_err to 0.
REQ-029 SHALL, on reset asserted mid-frame, abandon the frame with no output pulse; after release, the first start bit SHALL be found only on a fresh line low.

Verification
REQ-030 SHALL cover: Prescale=8, PAR_EN=0, send 0xA5 -> P_data=0xA5, single Data_valid pulse, 84 cycles after start edge, no error pulses.
REQ-031 SHALL cover: Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> Data_valid, P_data=0x3C; repeat with parity 1 -> Par_err pulse, no Data_valid, P_data still 0x3C.
REQ-032 SHALL cover: Prescale=8, stop bit driven 0 for the 0x5A frame -> Stp_err pulse, no Data_valid.
REQ-033 SHALL cover: line low for 3 cycles then high (Prescale=16) -> FSM back in IDLE, no pulses; a following valid 0x81 frame is received correctly.
REQ-034 SHALL cover: two back-to-back frames 0x12, 0x34 at Prescale=32 -> two Data_valid pulses, P_data 0x12 then 0x34.
REQ-035 SHALL cover: rst pulsed during DATA bit 4, then frame 0xF0 -> no output for the aborted frame; P_data=0xF0 with one Data_valid.
